dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the RISC-V core's load/store path. The core side initiates requests over a valid/ready handshake; this block services them from word-organised storage after a programmable number of wait states. It performs RV32I byte, halfword and word access, with sign or zero extension, store byte-lane merging and access-fault detection. It replaces the zero-latency data memory so the core can be exercised against realistic memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 1024 — storage size in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1 — extra wait cycles per access; legal range 0..7.

Ports:
- clk  in  1  — single clock; all state changes on its rising edge.
- reset  in  1  — synchronous, active-low; sampled on rising clk.
- req_valid  in  1  — the core presents a request.
- req_ready  out  1  — the block accepts a request this cycle.
- req_write  in  1  — 1 = store, 0 = load.
- req_funct3  in  3  — RV32I width/sign code from the instruction.
- req_addr  in  32  — byte address (the ALU result).
- req_wdata  in  32  — store data (rs2); low bits are used for SB/SH.
- rsp_valid  out  1  — response available.
- rsp_ready  in  1  — the core takes the response.
- rsp_rdata  out  32  — load result, extended to 32 bits; 0 for stores and faults.
- rsp_err  out  1  — access fault; qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready = 1, except while reset is low.
  - On req_valid && req_ready, latch write, funct3, addr and wdata; load the counter with WAIT_STATES; go to WAIT.
- **WAIT**
  - If the counter is nonzero, decrement it and stay in WAIT.
  - If the counter is 0, perform the access at this edge, register rsp_rdata and rsp_err, and go to RESP.
- **RESP**
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE and clear rsp_valid. rsp_rdata and rsp_err return to 0.
- **Legal funct3 codes**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is a fault.
- **Fault conditions** (any one sets rsp_err = 1, rsp_rdata = 0, and no storage write):
  - illegal funct3;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - addr[31:2] >= DEPTH_WORDS.
- **Loads**
  - Word index = addr[31:2].
  - Byte loads select lane addr[1:0]; halfword loads select lane addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **Stores**
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes halfword lane addr[1] with wdata[15:0].
  - SW writes the full word. Unselected lanes keep their old value.
  - A store response returns rsp_rdata = 0.
- The storage array is not cleared by reset. Its contents are undefined until written; benches must write before reading.
- The request fields are captured at acceptance. Changes on req_* after that have no effect on the access in flight.

## Timing
- **Reset values:** state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0. req_ready = 0 while reset is low.
- **Latency:** acceptance edge k → access performed at edge k+WAIT_STATES+1 → rsp_valid high in the following cycle.
- **Throughput:** with rsp_ready held high, the response handshakes at edge k+WAIT_STATES+2, and the next request can be accepted at edge k+WAIT_STATES+3.
- **No overlap:** the block never has more than one request in flight. req_ready = 0 throughout WAIT and RESP.
- **Response backpressure:** rsp_valid stays high with data held for any number of cycles while rsp_ready = 0.
- **Reset mid-operation:** reset low at any edge forces IDLE and the reset values at that edge.
  - A store still in WAIT at that edge is discarded; the array is unchanged.
  - A store already performed stays written.
- **Reset and request together:** reset low at the same edge as req_valid → the request is not accepted.
- **WAIT_STATES = 0:** WAIT lasts exactly one cycle; the access happens at edge k+1.

## Test plan
- **SW then LW (WAIT_STATES = 1):** SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → rsp_rdata 0xDEADBEEF, rsp_err 0. rsp_valid rises 2 cycles after acceptance.
- **Byte/half extension:** SW 0x20 ← 0x80FF7F01, then:
  - LB 0x23 → 0xFFFFFF80
  - LBU 0x23 → 0x00000080
  - LH 0x22 → 0xFFFF80FF
  - LHU 0x20 → 0x00007F01
- **Lane merge:** SW 0x30 ← 0x11223344; SB 0x31 ← 0xAA; SH 0x32 ← 0xBBCC; LW 0x30 → 0xBBCCAA44.
- **Faults:**
  - LW 0x06, LH 0x05, and funct3 011 each → rsp_err 1, rsp_rdata 0.
  - SW to address 4*DEPTH_WORDS → rsp_err 1, and a following read-back of the target word is unchanged.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err are stable and req_ready = 0. Release → IDLE next cycle.
- **Reset mid-op (WAIT_STATES = 3):** SW 0x40 ← 0x12345678, assert reset during WAIT → rsp_valid never rises. A later LW 0x40 returns the prior value.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle RV32I data-memory responder. Accepts one load or
//                store over a valid/ready request channel, waits a fixed
//                number of cycles, performs the access against word-organised
//                storage and returns the result over a valid/ready response
//                channel. Handles byte/halfword/word sizing, sign/zero
//                extension, store lane merging and access-fault detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);
    localparam logic [2:0]  c_wait  = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Request fields captured at acceptance
    logic                r_write;
    logic [2:0]          r_funct3;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_cnt;

    // Registered response
    logic [31:0]         r_rdata;
    logic                r_err;

    // Storage (not reset)
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_access;
    logic [c_idx_w-1:0]  w_idx;
    logic [31:0]         w_rd_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_in_range;
    logic                w_legal;
    logic                w_misalign;
    logic                w_fault;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;

    assign w_accept   = req_valid && req_ready;
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 3'd0);
    assign w_idx      = r_addr[c_idx_w+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_byte     = w_rd_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    assign w_in_range = ({2'b00, r_addr[31:2]} < c_depth);
    assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_fault    = !w_legal || w_misalign || !w_in_range;

    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

    // Legal width codes: stores only take the three unsigned-less sizes
    always_comb begin
        w_legal = 1'b0;
        case (r_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !r_write;
            default:                w_legal = 1'b0;
        endcase
    end

    // Load result: lane select plus sign or zero extension
    always_comb begin
        w_load = 32'd0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_rd_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // Store data merged into the old word so unselected lanes are preserved
    always_comb begin
        w_merge = w_rd_word;
        case (r_funct3[1:0])
            2'b00: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_addr[1]) begin
                    w_merge[31:16] = r_wdata[15:0];
                end else begin
                    w_merge[15:0]  = r_wdata[15:0];
                end
            end
            2'b10:   w_merge = r_wdata;
            default: w_merge = w_rd_word;
        endcase
    end

    // Next-state and handshake outputs; req_ready is forced low while in reset
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = reset;
                if (w_accept) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, wait counter and response registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_cnt    <= 3'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_cnt    <= c_wait;
            end
            if ((r_state == S_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_access) begin
                r_rdata <= (w_fault || r_write) ? 32'd0 : w_load;
                r_err   <= w_fault;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage write; a store caught by reset before its access never lands
    always_ff @(posedge clk) begin
        if (reset && w_access && r_write && !w_fault) begin
            r_mem[w_idx] <= w_merge;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Two instances with
//                different wait-state counts are driven with directed and
//                random transactions and compared against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int WS_A  = 1;
    localparam int WS_B  = 3;

    logic        clk = 1'b0;
    logic [1:0]  reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata  [2];
    logic [1:0]  rsp_err;

    logic [7:0]  mdl [2][4*DEPTH];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .reset(reset_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
        .clk(clk), .reset(reset_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: RV32I memory semantics over a flat byte array
    task automatic model_access(input int d, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic e);
        bit          legal;
        int          size;
        logic [31:0] v;
        legal = wr ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        size  = 1 << f3[1:0];
        e     = !legal || ((a % size) != 0) || ((a >> 2) >= DEPTH);
        rd    = 32'd0;
        if (!e) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mdl[d][int'(a) + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
            end
        end
    endtask

    // One complete transaction with latency, hold and release checks
    task automatic xact(input int d, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] held_d;
        logic        held_e;
        int          lat;
        bit          got;
        model_access(d, wr, f3, a, wd, exp_d, exp_e);
        @(negedge clk);
        check("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_write[d]  = 1'($urandom);
        req_funct3[d] = 3'($urandom);
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid[d]) got = 1'b1;
            else check("busy_ready", 32'(req_ready[d]), 32'd0);
        end
        check("latency", 32'(lat), 32'(ws(d) + 1));
        check("rdata", rsp_rdata[d], exp_d);
        check("err", 32'(rsp_err[d]), 32'(exp_e));
        held_d = exp_d;
        held_e = exp_e;
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid[d]), 32'd1);
            check("hold_rdata", rsp_rdata[d], held_d);
            check("hold_err", 32'(rsp_err[d]), 32'(held_e));
            check("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check("post_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_rdata", rsp_rdata[d], 32'd0);
        check("post_err", 32'(rsp_err[d]), 32'd0);
        check("post_ready", 32'(req_ready[d]), 32'd1);
    endtask

    // SW accepted at edge k, reset low at edge k+n together with a new request
    task automatic abort_store(input int d, input logic [31:0] a, input logic [31:0] wd, input int n);
        logic [31:0] dd;
        logic        de;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_write[d]  = 1'b1;
        req_funct3[d] = 3'b010;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        reset_n[d]   = 1'b0;
        req_valid[d] = 1'b1;
        req_wdata[d] = ~wd;
        @(posedge clk);
        #1;
        check("abort_valid", 32'(rsp_valid[d]), 32'd0);
        check("abort_rdata", rsp_rdata[d], 32'd0);
        check("abort_err", 32'(rsp_err[d]), 32'd0);
        check("abort_ready", 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        reset_n[d]   = 1'b1;
        if (n >= ws(d) + 2) model_access(d, 1'b1, 3'b010, a, wd, dd, de);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("abort_quiet", 32'(rsp_valid[d]), 32'd0);
        end
        check("abort_idle", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          wr;
        reset_n   = 2'b00;
        req_valid = 2'b00;
        req_write = 2'b00;
        rsp_ready = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_funct3[d] = 3'd0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rdata", rsp_rdata[d], 32'd0);
            check("rst_err", 32'(rsp_err[d]), 32'd0);
            check("rst_ready", 32'(req_ready[d]), 32'd0);
        end
        reset_n = 2'b11;

        // Fill both memories so every later load is defined
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                xact(d, 1'b1, 3'b010, 32'(w * 4), $urandom, 0);

        // Directed cases on the single-wait-state instance
        xact(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, 0);
        xact(0, 1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 0);
        xact(0, 1'b0, 3'b000, 32'h23, 32'h0, 0);
        xact(0, 1'b0, 3'b100, 32'h23, 32'h0, 0);
        xact(0, 1'b0, 3'b001, 32'h22, 32'h0, 0);
        xact(0, 1'b0, 3'b101, 32'h20, 32'h0, 0);
        xact(0, 1'b1, 3'b010, 32'h30, 32'h1122_3344, 0);
        xact(0, 1'b1, 3'b000, 32'h31, 32'h0000_00AA, 0);
        xact(0, 1'b1, 3'b001, 32'h32, 32'h0000_BBCC, 0);
        xact(0, 1'b0, 3'b010, 32'h30, 32'h0, 5);
        xact(0, 1'b0, 3'b010, 32'h06, 32'h0, 0);
        xact(0, 1'b0, 3'b001, 32'h05, 32'h0, 0);
        xact(0, 1'b0, 3'b011, 32'h08, 32'h0, 0);
        xact(0, 1'b1, 3'b010, 32'(4 * DEPTH), 32'hCAFE_F00D, 0);
        xact(0, 1'b0, 3'b010, 32'h00, 32'h0, 0);
        xact(0, 1'b1, 3'b100, 32'h0C, 32'h5555_5555, 0);
        xact(0, 1'b0, 3'b010, 32'h0C, 32'h0, 0);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                wr = 1'($urandom);
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
                else if (wr) f3 = 3'($urandom_range(0, 2));
                else f3 = (3'($urandom_range(0, 4)) > 3'd2) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 19) == 0) a = $urandom;
                else a = 32'($urandom_range(0, 4 * DEPTH + 7));
                xact(d, wr, f3, a, $urandom, $urandom_range(0, 3));
            end
        end

        // Reset at successive edges after a store on the three-wait-state instance
        for (int n = 1; n <= 6; n++) begin
            abort_store(1, 32'(32'h40 + 4 * (n - 1)), $urandom, n);
            xact(1, 1'b0, 3'b010, 32'(32'h40 + 4 * (n - 1)), 32'h0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
